// File: rtl/cdd_pkg.sv
// Shared widths, iteration count and FSM state type for the 32/16 restoring divider.
package cdd_pkg;
  localparam int CDD_DW   = 32;
  localparam int CDD_QW   = 16;
  localparam int CDD_CNTW = 5;
  localparam int CDD_ITER = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/cdd_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract B.
module cdd_step
  import cdd_pkg::*;
(
  input  logic [CDD_QW-1:0] p,
  input  logic              din,
  input  logic [CDD_QW-1:0] b,
  output logic [CDD_QW-1:0] p_next,
  output logic              qbit
);
  logic [CDD_QW:0] t;

  assign t    = {p, din};
  assign qbit = (t >= {1'b0, b});
  // Only the low 16 bits of the partial remainder feed the next iteration, so
  // the subtraction is done modulo 2^16 and the 17th bit is never stored.
  assign p_next = t[CDD_QW-1:0] - (qbit ? b : '0);
endmodule

// File: rtl/cdd32_16_seq.sv
// Sequential 32/16 unsigned restoring divider, one iteration per clock, valid/ready on both sides.
// Optional overflow/divide-by-zero fast path and err flag: define CDD_OVF_DETECT_EN.
module cdd32_16_seq
  import cdd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CDD_DW-1:0] A,
  input  logic [CDD_QW-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CDD_QW-1:0] Q,
  output logic [CDD_QW-1:0] R,
  output logic              err
);
  state_t              state, nxt;
  logic                armed;
  logic [CDD_QW-1:0]   p, d, b_q, qr;
  logic [CDD_CNTW-1:0] cnt;
  logic [CDD_QW-1:0]   p_step;
  logic                qbit;
  logic                acc, fast, last;

  cdd_step u_step (
    .p      (p),
    .din    (d[CDD_QW-1]),
    .b      (b_q),
    .p_next (p_step),
    .qbit   (qbit)
  );

  assign acc  = in_valid && in_ready;
  assign last = (cnt == CDD_CNTW'(CDD_ITER - 1));
`ifdef CDD_OVF_DETECT_EN
  assign fast = (B == '0) || (A[CDD_DW-1:CDD_QW] >= B);
`else
  assign fast = 1'b0;
`endif

  // armed keeps in_ready low while rst is sampled high, so in_ready stays a
  // pure function of registered state.
  assign in_ready  = armed && (state == IDLE);
  assign out_valid = (state == DONE);
  assign Q         = qr;
  assign R         = p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) nxt = fast ? DONE : BUSY;
      BUSY: if (last) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= '0;
      d   <= '0;
      b_q <= '0;
      qr  <= '0;
      cnt <= '0;
    end else if (state == IDLE && acc) begin
      b_q <= B;
      cnt <= '0;
      if (fast) begin
        p  <= A[CDD_QW-1:0];
        qr <= '1;
      end else begin
        p <= A[CDD_DW-1:CDD_QW];
        d <= A[CDD_QW-1:0];
      end
    end else if (state == BUSY) begin
      p   <= p_step;
      d   <= {d[CDD_QW-2:0], 1'b0};
      qr  <= {qr[CDD_QW-2:0], qbit};
      cnt <= cnt + CDD_CNTW'(1);
    end
  end

`ifdef CDD_OVF_DETECT_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                       err_q <= 1'b0;
    else if (state == IDLE && acc) err_q <= fast;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
